shift_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the tainted 2-operand shift datapath used in IFT cell tests. Accepts one shift request (operand A, amount B, per-operand taint labels) over a valid/ready handshake. Performs the shift one bit position per clock and returns result Y with taint label Y_t over a second valid/ready handshake. Sits between a request source (bench or IFT harness) and the result consumer; owns the shared shift resource, serialising all requests.

---
 rtl/shift_seq_ctrl.sv | 116 +++++++++++
 tb/tb_shift_seq_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Serial shift sequencer: accepts one request, shifts one bit per clock, returns Y and taint union.
// Latency n+1 cycles from accept; in_ready low while busy, result held until out_ready.
module shift_seq_ctrl #(
  parameter int WIDTH   = 8,
  parameter int SHW     = 4,
  parameter int TAINT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [TAINT_W-1:0] in_a_t,
  input  logic [SHW-1:0]     in_b,
  input  logic [TAINT_W-1:0] in_b_t,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_y,
  output logic [TAINT_W-1:0] out_y_t,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     work_q, work_d, step;
  logic [1:0]           op_q, op_d;
  logic [TAINT_W-1:0]   yt_q, yt_d;
  logic [CW-1:0]        cnt_q, cnt_d, n_eff;
  logic                 accept;

  assign accept = in_valid && in_ready;

  // Rotations wrap modulo WIDTH; plain shifts saturate at WIDTH so the counter never wraps.
  always_comb begin
    if (in_op == 2'd3) begin
      n_eff = CW'(int'(in_b) % WIDTH);
    end else if (int'(in_b) >= WIDTH) begin
      n_eff = CW'(WIDTH);
    end else begin
      n_eff = CW'(in_b);
    end
  end

  always_comb begin
    step = work_q;
    case (op_q)
      2'd0: step = {work_q[WIDTH-2:0], 1'b0};
      2'd1: step = {1'b0, work_q[WIDTH-1:1]};
      2'd2: step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      2'd3: step = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      default: step = work_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (n_eff == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == SHIFT) || (state_q == DONE);
  end

  always_comb begin
    work_d = work_q;
    op_d   = op_q;
    yt_d   = yt_q;
    cnt_d  = cnt_q;
    if (accept) begin
      work_d = in_a;
      op_d   = in_op;
      yt_d   = in_a_t | in_b_t;
      cnt_d  = n_eff;
    end else if (state_q == SHIFT) begin
      work_d = step;
      cnt_d  = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
      op_q   <= '0;
      yt_q   <= '0;
      cnt_q  <= '0;
    end else begin
      work_q <= work_d;
      op_q   <= op_d;
      yt_q   <= yt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_y   = work_q;
  assign out_y_t = yt_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: arithmetic reference model plus scoreboard, directed and sweep vectors.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [31:0] in_a_t = '0;
  logic [3:0]  in_b = '0;
  logic [31:0] in_b_t = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_y;
  logic [31:0] out_y_t;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0]  y;
    logic [31:0] t;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  shift_seq_ctrl #(.WIDTH(8), .SHW(4), .TAINT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_a_t(in_a_t), .in_b(in_b), .in_b_t(in_b_t), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_y_t(out_y_t), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] a, input logic [3:0] b, input logic [1:0] op);
    logic [15:0] w;
    int r;
    case (op)
      2'd0: begin w = {8'h00, a} << b; return w[7:0]; end
      2'd1: return a >> b;
      2'd2: return 8'($signed(a) >>> b);
      default: begin r = int'(b) % 8; w = {a, a} << r; return w[15:8]; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] b, input logic [1:0] op);
    if (op == 2'd3) return (int'(b) % 8) + 1;
    return ((int'(b) > 8) ? 8 : int'(b)) + 1;
  endfunction

  // Scoreboard: every valid result must match the oldest outstanding request.
  logic prev_vld = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_vld = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {63'd0, out_valid}, 64'd0);
        end else begin
          if (!prev_vld) chk("latency", 64'(cyc), 64'(exp_q[0].due));
          chk("out_y", {56'd0, out_y}, {56'd0, exp_q[0].y});
          chk("out_y_t", {32'd0, out_y_t}, {32'd0, exp_q[0].t});
          chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_vld = out_valid;
    end
  end

  task automatic send(input logic [7:0] a, input logic [3:0] b, input logic [1:0] op,
                      input logic [31:0] at, input logic [31:0] bt);
    exp_t e;
    int k;
    @(negedge clk);
    in_a = a; in_b = b; in_op = op; in_a_t = at; in_b_t = bt; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    if (!in_ready) begin
      chk("send_timeout", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
      return;
    end
    e.y = ref_shift(a, b, op);
    e.t = at | bt;
    e.due = cyc + ref_lat(b, op);
    exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin @(negedge clk); k++; end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Hand-computed vector: pins the model against the literal, then lets the scoreboard check the DUT.
  task automatic lit(input logic [7:0] a, input logic [3:0] b, input logic [1:0] op,
                     input logic [7:0] ey, input int elat);
    chk("model_y", {56'd0, ref_shift(a, b, op)}, {56'd0, ey});
    chk("model_lat", 64'(ref_lat(b, op)), 64'(elat));
    send(a, b, op, 32'h1, 32'h4);
    drain();
  endtask

  task automatic idle_state(input string tag);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_out_y"}, {56'd0, out_y}, 64'd0);
    chk({tag, "_out_y_t"}, {32'd0, out_y_t}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [31:0] at, bt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_state("reset");

    lit(8'h81, 4'd1, 2'd0, 8'h02, 2);
    lit(8'h80, 4'd3, 2'd2, 8'hF0, 4);
    lit(8'h80, 4'd9, 2'd2, 8'hFF, 9);
    lit(8'hFF, 4'd0, 2'd1, 8'hFF, 1);
    lit(8'hFF, 4'd15, 2'd0, 8'h00, 9);
    lit(8'h81, 4'd9, 2'd3, 8'h03, 2);
    lit(8'h5A, 4'd8, 2'd3, 8'h5A, 1);
    chk("model_taint", {32'd0, 32'h1 | 32'h4}, 64'h5);

    // Backpressure: result held for 5 cycles while a stray request is offered.
    out_ready = 1'b0;
    send(8'h3C, 4'd2, 2'd1, 32'hA000_0000, 32'h0000_0003);
    begin
      int k = 0;
      while (!out_valid && k < 50) begin @(negedge clk); k++; end
      chk("bp_reach_done", {63'd0, out_valid}, 64'd1);
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_busy", {63'd0, busy}, 64'd1);
      chk("bp_y_literal", {56'd0, out_y}, 64'h0F);
      if (i == 1) begin
        in_a = 8'hFF; in_b = 4'd0; in_op = 2'd0; in_a_t = 32'hFFFF_FFFF; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
    repeat (3) @(negedge clk);

    // Reset during SHIFT discards the pending result.
    send(8'h81, 4'd7, 2'd0, 32'h10, 32'h20);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_state("mid_reset");
    repeat (15) @(negedge clk);

    // Sweep small operands over every op and taint pattern.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int op = 0; op < 4; op++)
          for (int p = 0; p < 4; p++) begin
            at = p[0] ? 32'h0000_0011 : 32'h0;
            bt = p[1] ? 32'h0000_0100 : 32'h0;
            send(8'(a), 4'(b), 2'(op), at, bt);
          end
    drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
